// File: rtl/shift_pkg.sv
// Shared definitions for the shifter scheduler: op encodings, FSM states, default widths.
package shift_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned SW_DEF = 4;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PASS1 = 2'b01;
  localparam logic [1:0] ST_PASS2 = 2'b10;
  localparam logic [1:0] ST_RESP  = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt_c
);

  logic r_prio;

  always_comb begin
    o_gnt_c = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt_c = 2'b01;
        2'b10:   o_gnt_c = 2'b10;
        2'b11:   o_gnt_c = r_prio ? 2'b10 : 2'b01;
        default: o_gnt_c = 2'b00;
      endcase
    end
  end

  // Priority passes to the requester that was not just granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= RR_INIT;
    end else if (|o_gnt_c) begin
      r_prio <= o_gnt_c[0];
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Shares one combinational shifter between two requesters; sequences SLL/SRL/SRA in one
// pass and ROR in two (SRL n, then SLL 16-n, ORed), returning results over valid/ready.
module shift_sched
  import shift_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned SW      = SW_DEF,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [DW-1:0] req_src0,
  input  logic [DW-1:0] req_src1,
  input  logic [SW-1:0] req_shamt0,
  input  logic [SW-1:0] req_shamt1,
  input  logic [1:0]    req_op0,
  input  logic [1:0]    req_op1,
  output logic [DW-1:0] sh_src0,
  output logic [SW-1:0] sh_shamt,
  output logic          sh_srl,
  output logic          sh_sra,
  output logic          sh_ls,
  input  logic [DW-1:0] sh_opt,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          resp_id
);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [DW-1:0] r_src;
  logic [SW-1:0] r_shamt;
  logic [1:0]    r_op;
  logic          r_id;
  logic [DW-1:0] r_res;
  logic [1:0]    w_gnt;
  logic          w_idle;
  logic          w_accept;
  logic          w_sel;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = |w_gnt;
  assign w_sel    = w_gnt[1];

  rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (req_valid),
    .i_en    (w_idle),
    .o_gnt_c (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and shifter control decode; controls are zero outside the two passes.
  always_comb begin
    w_state_nxt = r_state;
    sh_shamt    = '0;
    sh_srl      = 1'b0;
    sh_sra      = 1'b0;
    sh_ls       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_PASS1;
      end
      ST_PASS1: begin
        sh_shamt    = r_shamt;
        sh_ls       = (r_op == SH_SLL);
        sh_srl      = (r_op == SH_SRL) || (r_op == SH_ROR);
        sh_sra      = (r_op == SH_SRA);
        w_state_nxt = (r_op == SH_ROR) ? ST_PASS2 : ST_RESP;
      end
      ST_PASS2: begin
        sh_shamt    = SW'(SW'(0) - r_shamt);
        sh_ls       = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= '0;
      r_shamt <= '0;
      r_op    <= SH_SLL;
      r_id    <= 1'b0;
      r_res   <= '0;
    end else begin
      if (w_accept) begin
        r_src   <= w_sel ? req_src1   : req_src0;
        r_shamt <= w_sel ? req_shamt1 : req_shamt0;
        r_op    <= w_sel ? req_op1    : req_op0;
        r_id    <= w_sel;
      end
      if (r_state == ST_PASS1) begin
        r_res <= sh_opt;
      end else if (r_state == ST_PASS2) begin
        r_res <= r_res | sh_opt;
      end
    end
  end

  assign req_ready  = w_gnt;
  assign sh_src0    = r_src;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_data  = r_res;
  assign resp_id    = r_id;

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched with a behavioural shifter and an arithmetic reference model.
module tb_shift_sched;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_src0, req_src1;
  logic [3:0]  req_shamt0, req_shamt1;
  logic [1:0]  req_op0, req_op1;
  logic [15:0] sh_src0;
  logic [3:0]  sh_shamt;
  logic        sh_srl, sh_sra, sh_ls;
  logic [15:0] sh_opt;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_id;

  int n_chk = 0;
  int n_err = 0;
  logic last_gnt;

  always #5 clk = ~clk;

  shift_sched #(.DW(16), .SW(4), .RR_INIT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src0   (req_src0),
    .req_src1   (req_src1),
    .req_shamt0 (req_shamt0),
    .req_shamt1 (req_shamt1),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .sh_src0    (sh_src0),
    .sh_shamt   (sh_shamt),
    .sh_srl     (sh_srl),
    .sh_sra     (sh_sra),
    .sh_ls      (sh_ls),
    .sh_opt     (sh_opt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  // External shared shifter: ls / srl / sra, otherwise pass-through.
  always_comb begin
    if (sh_ls)       sh_opt = sh_src0 << sh_shamt;
    else if (sh_srl) sh_opt = sh_src0 >> sh_shamt;
    else if (sh_sra) sh_opt = 16'($signed(sh_src0) >>> sh_shamt);
    else             sh_opt = sh_src0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_chk++;
      assert ($countones({sh_srl, sh_sra, sh_ls}) <= 1) else begin
        n_err++;
        $error("FAIL onehot: observed=%b expected=at most one set", {sh_srl, sh_sra, sh_ls});
      end
    end
  end

  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] src,
                                            input logic [3:0] n);
    logic [31:0] dbl;
    case (op)
      SH_SLL:  ref_shift = src << n;
      SH_SRL:  ref_shift = src >> n;
      SH_SRA:  ref_shift = 16'($signed(src) >>> n);
      default: begin
        dbl       = {src, src} >> n;
        ref_shift = dbl[15:0];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input bit id, input logic [1:0] op, input logic [15:0] src,
                         input logic [3:0] n);
    if (id) begin
      req_op1 = op; req_src1 = src; req_shamt1 = n; req_valid[1] = 1'b1;
    end else begin
      req_op0 = op; req_src0 = src; req_shamt0 = n; req_valid[0] = 1'b1;
    end
  endtask

  task automatic wait_grant(input bit id);
    int cyc;
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("grant", 32'(req_ready), id ? 32'h2 : 32'h1);
    last_gnt = id;
  endtask

  // Called at the negedge where the grant is visible; runs the op to completion.
  task automatic finish_op(input bit id, input logic [1:0] op, input logic [15:0] src,
                           input logic [3:0] n, input int hold);
    logic [15:0] e;
    logic [2:0]  ctl;
    logic [3:0]  n2;
    int          cyc;
    e   = ref_shift(op, src, n);
    ctl = (op == SH_SLL) ? 3'b001 : (op == SH_SRA) ? 3'b010 : 3'b100;
    n2  = 4'(5'd16 - {1'b0, n});
    step();
    req_valid[id] = 1'b0;
    cyc = 1;
    chk("p1_ctl",   32'({sh_srl, sh_sra, sh_ls}), 32'(ctl));
    chk("p1_shamt", 32'(sh_shamt), 32'(n));
    chk("p1_src",   32'(sh_src0), 32'(src));
    if (op == SH_ROR) begin
      step();
      cyc++;
      chk("p2_ctl",   32'({sh_srl, sh_sra, sh_ls}), 32'h1);
      chk("p2_shamt", 32'(sh_shamt), 32'(n2));
    end
    while (!resp_valid && cyc < 10) begin
      step();
      cyc++;
    end
    chk("latency", 32'(cyc), (op == SH_ROR) ? 32'd3 : 32'd2);
    chk("resp_data", 32'(resp_data), 32'(e));
    chk("resp_id", 32'(resp_id), 32'(id));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("stall_valid", 32'(resp_valid), 32'h1);
      chk("stall_data", 32'(resp_data), 32'(e));
      chk("stall_id", 32'(resp_id), 32'(id));
      chk("stall_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_done", 32'(resp_valid), 32'h0);
  endtask

  task automatic do_op(input bit id, input logic [1:0] op, input logic [15:0] src,
                       input logic [3:0] n);
    set_req(id, op, src, n);
    wait_grant(id);
    finish_op(id, op, src, n, 0);
  endtask

  logic [1:0]  pop[2];
  logic [15:0] psrc[2];
  logic [3:0]  pn[2];
  logic [15:0] qd[$];
  logic        qi[$];

  initial begin
    int  grants, g0, guard, pend;
    bit  id;
    logic [15:0] d;
    logic        di;
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b0;
    req_src0 = '0; req_src1 = '0; req_shamt0 = '0; req_shamt1 = '0;
    req_op0 = '0; req_op1 = '0;
    last_gnt = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_data", 32'(resp_data), 32'h0);
    chk("rst_ctl", 32'({sh_srl, sh_sra, sh_ls, sh_shamt, sh_src0}), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    step();

    // Directed: SRA sign fill, then two-pass ROR.
    do_op(1'b0, SH_SRA, 16'h8F00, 4'd4);
    do_op(1'b1, SH_ROR, 16'h1234, 4'd4);

    // Both requesters always valid: grants alternate, results in order.
    for (int i = 0; i < 2; i++) begin
      pop[i] = 2'($urandom); psrc[i] = 16'($urandom); pn[i] = 4'($urandom);
      set_req(1'(i), pop[i], psrc[i], pn[i]);
    end
    resp_ready = 1'b1;
    grants = 0; g0 = 0; guard = 0;
    while (grants < 20 && guard < 300) begin
      pend = -1;
      if (resp_valid) begin
        d = qd.pop_front(); di = qi.pop_front();
        chk("rr_data", 32'(resp_data), 32'(d));
        chk("rr_id", 32'(resp_id), 32'(di));
      end
      if (req_ready != 2'b00) begin
        chk("rr_grant", 32'(req_ready), last_gnt ? 32'h1 : 32'h2);
        id = req_ready[1];
        qd.push_back(ref_shift(pop[id], psrc[id], pn[id]));
        qi.push_back(id);
        last_gnt = id;
        if (!id) g0++;
        grants++;
        pend = int'(id);
      end
      step();
      guard++;
      if (pend >= 0) begin
        pop[pend] = 2'($urandom); psrc[pend] = 16'($urandom); pn[pend] = 4'($urandom);
        set_req(1'(pend), pop[pend], psrc[pend], pn[pend]);
      end
    end
    req_valid = 2'b00;
    guard = 0;
    while (qd.size() > 0 && guard < 20) begin
      if (resp_valid) begin
        d = qd.pop_front(); di = qi.pop_front();
        chk("rr_data", 32'(resp_data), 32'(d));
        chk("rr_id", 32'(resp_id), 32'(di));
      end
      step();
      guard++;
    end
    chk("rr_drained", 32'(qd.size()), 32'h0);
    chk("rr_count0", 32'(g0), 32'd10);
    resp_ready = 1'b0;
    step();

    // Stall in RESP while requester 1 waits, then it is granted.
    set_req(1'b0, SH_SLL, 16'h00F3, 4'd3);
    wait_grant(1'b0);
    set_req(1'b1, SH_SRL, 16'hF00F, 4'd5);
    finish_op(1'b0, SH_SLL, 16'h00F3, 4'd3, 5);
    wait_grant(1'b1);
    finish_op(1'b1, SH_SRL, 16'hF00F, 4'd5, 0);

    // shamt boundaries.
    for (int op = 0; op < 4; op++) do_op(1'b0, 2'(op), 16'hA5A5, 4'd0);
    chk("ref_sll15", 32'(ref_shift(SH_SLL, 16'h0001, 4'd15)), 32'h8000);
    do_op(1'b1, SH_SLL, 16'h0001, 4'd15);

    // Random single-requester traffic.
    for (int i = 0; i < 16; i++) begin
      do_op(1'($urandom), 2'($urandom), 16'($urandom), 4'($urandom));
    end

    // Reset during ROR pass 2 aborts the operation.
    set_req(1'b1, SH_ROR, 16'hBEEF, 4'd7);
    wait_grant(1'b1);
    step();
    req_valid = 2'b00;
    step();
    chk("p2_before_rst", 32'({sh_srl, sh_sra, sh_ls}), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(resp_valid), 32'h0);
    chk("arst_data", 32'(resp_data), 32'h0);
    chk("arst_ctl", 32'({sh_srl, sh_sra, sh_ls, sh_shamt, sh_src0}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_gnt = 1'b1;
    step();
    do_op(1'b0, SH_SLL, 16'h1357, 4'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
